jt49_cengen: RTL

JT49_CENGEN -- requirements
Module: jt49_cengen

---
 rtl/jt49_cengen.sv | 105 ++++++++++
 1 files changed

// File: rtl/jt49_cengen.sv
// Fractional clock-enable generator: a num/den accumulator produces a base
// enable pulse, and a free-running counter derives power-of-two divided taps.
module jt49_cengen #(
    parameter int          NOUT = 2,
    parameter int          CW   = 10,
    parameter int          FW   = 16,
    parameter int          DW   = 4,
    parameter int unsigned NUM0 = 1,
    parameter int unsigned DEN0 = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cen,
    input  logic               sel,
    input  logic               sync,
    input  logic               load,
    input  logic [FW-1:0]      num,
    input  logic [FW-1:0]      den,
    input  logic [NOUT*DW-1:0] div,
    output logic               cen_base,
    output logic [NOUT-1:0]    cen_o
);

    logic [FW-1:0]   num_q, den_q;
    logic [FW:0]     acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            base_q, base_d;
    logic [NOUT-1:0] tap_q, tap_d;
    logic [NOUT-1:0] match;

    logic [FW-1:0]   n_eff;
    logic [FW:0]     den_ext, sum;

    // Clamping the numerator to the denominator keeps acc below den_q.
    assign n_eff   = (num_q < den_q) ? num_q : den_q;
    assign den_ext = {1'b0, den_q};
    assign sum     = acc_q + {1'b0, n_eff};

    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        base_d = 1'b0;
        if (sync) begin
            acc_d = '0;
            cnt_d = '0;
        end else if ((den_q != '0) && (acc_q >= den_ext)) begin
            // A freshly loaded den below the running acc restarts the phase.
            acc_d = '0;
        end else if (cen && (den_q != '0)) begin
            if (sum >= den_ext) begin
                base_d = 1'b1;
                acc_d  = sum - den_ext;
                cnt_d  = cnt_q + 1'b1;
            end else begin
                acc_d = sum;
            end
        end
    end

    for (genvar i = 0; i < NOUT; i++) begin : g_tap
        logic [31:0] sh;
        logic        tap_match;

        always_comb begin
            sh = {{(32-DW){1'b0}}, div[i*DW +: DW]} + {31'd0, ~sel};
            if (sh > 32'(CW)) begin
                sh = 32'(CW);
            end
            tap_match = 1'b1;
            for (int b = 0; b < CW; b++) begin
                if ((32'(b) < sh) && cnt_q[b]) begin
                    tap_match = 1'b0;
                end
            end
        end

        assign match[i] = tap_match;
    end

    assign tap_d = base_d ? match : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q  <= FW'(NUM0);
            den_q  <= FW'(DEN0);
            acc_q  <= '0;
            cnt_q  <= '0;
            base_q <= 1'b0;
            tap_q  <= '0;
        end else begin
            if (load) begin
                num_q <= num;
                den_q <= den;
            end
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            base_q <= base_d;
            tap_q  <= tap_d;
        end
    end

    assign cen_base = base_q;
    assign cen_o    = tap_q;

endmodule
